// File: rtl/zclock_gen.sv
// Z80 clock generator: derives zpos/zneg strobes and the inverted zclk_out pin
// drive from fclk, phase-locked to the arbiter via sync, with wait stretching.
module zclock_gen #(
  parameter int PHASE_BITS  = 3,
  parameter int RFSH_SWITCH = 1
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       sync,
  input  logic [1:0] turbo,
  input  logic       rfsh_n,
  input  logic       wait_req,
  output logic       zclk_out,
  output logic       zpos,
  output logic       zneg,
  output logic [1:0] int_turbo,
  output logic       stalled
);

  localparam int MAX_MODE = PHASE_BITS - 1;

  logic [PHASE_BITS-1:0] r_ph;
  logic                  r_zpos;
  logic                  r_zneg;
  logic                  r_zclk;
  logic [1:0]            r_int_turbo;
  logic                  r_stalled;
  logic                  r_old_rfsh;
  logic                  r_arm;
  logic [1:0]            r_mode_req;

  logic [1:0]            w_turbo_sat;
  logic [PHASE_BITS-1:0] w_mask;
  logic [PHASE_BITS-1:0] w_half;
  logic [PHASE_BITS-1:0] w_ph_off;
  logic                  w_zpos_slot;
  logic                  w_zneg_slot;

  // The divider is a power of two, so "ph mod P" is a mask and P/2 is its top bit.
  assign w_turbo_sat = (int'(turbo) > MAX_MODE) ? 2'(MAX_MODE) : turbo;
  assign w_mask      = {PHASE_BITS{1'b1}} >> r_int_turbo;
  assign w_half      = w_mask & ~(w_mask >> 1);
  assign w_ph_off    = r_ph & w_mask;
  assign w_zpos_slot = (w_ph_off == '0);
  assign w_zneg_slot = (w_ph_off == w_half);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph        <= '0;
      r_zpos      <= 1'b0;
      r_zneg      <= 1'b0;
      r_zclk      <= 1'b1;
      r_int_turbo <= 2'd0;
      r_stalled   <= 1'b0;
      r_old_rfsh  <= 1'b1;
      r_arm       <= 1'b0;
      r_mode_req  <= 2'd0;
    end else begin
      r_ph   <= sync ? '0 : r_ph + 1'b1;
      r_zpos <= w_zpos_slot && !wait_req;
      r_zneg <= w_zneg_slot && !r_stalled;

      // A wait at a rising-edge slot holds the Z80 clock low until a later slot.
      if (w_zpos_slot) begin
        r_stalled <= wait_req;
      end

      if (r_zpos) begin
        r_zclk <= 1'b0;
      end else if (r_zneg) begin
        r_zclk <= 1'b1;
      end

      if (r_arm && (r_ph == '0) && !r_stalled) begin
        r_int_turbo <= r_mode_req;
        r_arm       <= 1'b0;
      end

      // Arming comes after the apply so a fresh request wins if both coincide.
      if (r_zpos) begin
        r_old_rfsh <= rfsh_n;
        if ((RFSH_SWITCH == 0) || (r_old_rfsh && !rfsh_n)) begin
          r_arm      <= 1'b1;
          r_mode_req <= w_turbo_sat;
        end
      end
    end
  end

  assign zpos      = r_zpos;
  assign zneg      = r_zneg;
  assign zclk_out  = r_zclk;
  assign int_turbo = r_int_turbo;
  assign stalled   = r_stalled;

endmodule

// File: tb/tb_zclock_gen.sv
// Scoreboard bench for zclock_gen: directed scenarios queue the expected strobe
// edges, and a negedge monitor pops and compares whenever zpos or zneg fires.
module tb_zclock_gen;

  logic       fclk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic [1:0] turbo;
  logic       rfsh_n;
  logic       wait_req;
  logic       zclk_out;
  logic       zpos;
  logic       zneg;
  logic [1:0] int_turbo;
  logic       stalled;

  int   checks  = 0;
  int   errors  = 0;
  int   edgeCnt = 0;
  int   phModel = 0;
  logic autoSync   = 1'b0;
  logic injectSync = 1'b0;

  typedef struct packed {
    int         atEdge;
    logic [1:0] mode;
    logic       zclk;
  } strobe_t;

  strobe_t zposQ[$];
  strobe_t znegQ[$];

  zclock_gen dut (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .sync      (sync),
    .turbo     (turbo),
    .rfsh_n    (rfsh_n),
    .wait_req  (wait_req),
    .zclk_out  (zclk_out),
    .zpos      (zpos),
    .zneg      (zneg),
    .int_turbo (int_turbo),
    .stalled   (stalled)
  );

  always #5 fclk = ~fclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  // One fclk cycle; sync recurs every 8 cycles unless injected early.
  task automatic tick();
    sync = (autoSync && (phModel == 7)) || injectSync;
    @(posedge fclk);
    #1;
    edgeCnt++;
    phModel = sync ? 0 : (phModel + 1) % 8;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) tick();
  endtask

  task automatic expectPos(input int e, input logic [1:0] m, input logic z);
    zposQ.push_back('{e, m, z});
  endtask

  task automatic expectNeg(input int e, input logic [1:0] m, input logic z);
    znegQ.push_back('{e, m, z});
  endtask

  always @(negedge fclk) begin
    strobe_t ev;
    if (zpos || zneg) checkOutput("strobes exclusive", 32'(zpos && zneg), 0);
    if (zpos) begin
      if (zposQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected zpos: actual edge %0d required none", edgeCnt);
      end else begin
        ev = zposQ.pop_front();
        checkOutput("zpos edge", edgeCnt, ev.atEdge);
        checkOutput("zpos int_turbo", 32'(int_turbo), 32'(ev.mode));
        checkOutput("zpos zclk_out", 32'(zclk_out), 32'(ev.zclk));
      end
    end
    if (zneg) begin
      if (znegQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected zneg: actual edge %0d required none", edgeCnt);
      end else begin
        ev = znegQ.pop_front();
        checkOutput("zneg edge", edgeCnt, ev.atEdge);
        checkOutput("zneg int_turbo", 32'(int_turbo), 32'(ev.mode));
        checkOutput("zneg zclk_out", 32'(zclk_out), 32'(ev.zclk));
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " zpos"}, 32'(zpos), 0);
    checkOutput({tag, " zneg"}, 32'(zneg), 0);
    checkOutput({tag, " zclk_out"}, 32'(zclk_out), 1);
    checkOutput({tag, " int_turbo"}, 32'(int_turbo), 0);
    checkOutput({tag, " stalled"}, 32'(stalled), 0);
  endtask

  initial begin
    rst_n    = 1'b1;
    sync     = 1'b0;
    turbo    = 2'd0;
    rfsh_n   = 1'b1;
    wait_req = 1'b0;
    #1 rst_n = 1'b0;
    applyStimulus(3);
    checkResetState("reset");

    // Mode 0 from release: ph=0 now, so zpos one edge later, period 8.
    $display("[TB] mode 0 after reset release");
    rst_n = 1'b1; phModel = 0; autoSync = 1'b1;
    expectPos(4, 2'd0, 1'b1);  expectNeg(8, 2'd0, 1'b0);
    expectPos(12, 2'd0, 1'b1); expectNeg(16, 2'd0, 1'b0);
    expectPos(20, 2'd0, 1'b1); expectNeg(24, 2'd0, 1'b0);
    applyStimulus(24);

    $display("[TB] reset while zclk_out low");
    expectPos(28, 2'd0, 1'b1);
    applyStimulus(2);
    checkOutput("zclk low before reset", 32'(zclk_out), 0);
    rst_n = 1'b0;
    #1;
    checkResetState("mid reset");
    applyStimulus(1);
    rst_n = 1'b1; phModel = 0;
    expectPos(31, 2'd0, 1'b1); expectNeg(35, 2'd0, 1'b0);
    expectPos(39, 2'd0, 1'b1); expectNeg(43, 2'd0, 1'b0);
    applyStimulus(16);

    $display("[TB] switch to mode 1 on rfsh_n fall");
    turbo = 2'd1; rfsh_n = 1'b1;
    expectPos(47, 2'd0, 1'b1); expectNeg(51, 2'd0, 1'b0);
    expectPos(55, 2'd0, 1'b1); expectNeg(59, 2'd0, 1'b0);
    expectPos(63, 2'd1, 1'b1); expectNeg(65, 2'd1, 1'b0);
    expectPos(67, 2'd1, 1'b1); expectNeg(69, 2'd1, 1'b0);
    expectPos(71, 2'd1, 1'b1); expectNeg(73, 2'd1, 1'b0);
    applyStimulus(2);
    rfsh_n = 1'b0;
    applyStimulus(14);
    checkOutput("mode 0 before ph0 apply", 32'(int_turbo), 0);
    applyStimulus(12);

    $display("[TB] turbo 3 saturates to mode 2");
    turbo = 2'd3; rfsh_n = 1'b1;
    expectPos(75, 2'd1, 1'b1); expectNeg(77, 2'd1, 1'b0);
    expectPos(79, 2'd1, 1'b1); expectNeg(81, 2'd1, 1'b0);
    expectPos(83, 2'd1, 1'b1); expectNeg(85, 2'd1, 1'b0);
    expectPos(87, 2'd2, 1'b1); expectNeg(88, 2'd2, 1'b0);
    expectPos(89, 2'd2, 1'b1); expectNeg(90, 2'd2, 1'b0);
    expectPos(91, 2'd2, 1'b1); expectNeg(92, 2'd2, 1'b0);
    expectPos(93, 2'd2, 1'b1); expectNeg(94, 2'd2, 1'b0);
    expectPos(95, 2'd2, 1'b1);
    applyStimulus(2);
    rfsh_n = 1'b0;
    applyStimulus(10);
    checkOutput("mode 1 before ph0 apply", 32'(int_turbo), 1);
    applyStimulus(9);

    $display("[TB] wait_req stall in mode 2");
    wait_req = 1'b1;
    expectNeg(96, 2'd2, 1'b0);
    expectPos(99, 2'd2, 1'b1);  expectNeg(100, 2'd2, 1'b0);
    expectPos(101, 2'd2, 1'b1); expectNeg(102, 2'd2, 1'b0);
    expectPos(103, 2'd2, 1'b1);
    applyStimulus(2);
    checkOutput("stalled set", 32'(stalled), 1);
    applyStimulus(1);
    checkOutput("stalled held", 32'(stalled), 1);
    checkOutput("zclk held during stall", 32'(zclk_out), 1);
    wait_req = 1'b0;
    applyStimulus(1);
    checkOutput("stalled cleared with zpos", 32'(stalled), 0);
    applyStimulus(4);

    $display("[TB] mode switch armed then stalled over ph0");
    rfsh_n = 1'b1; turbo = 2'd1;
    expectNeg(104, 2'd2, 1'b0);
    expectPos(105, 2'd2, 1'b1); expectNeg(106, 2'd2, 1'b0);
    expectPos(107, 2'd2, 1'b1); expectNeg(108, 2'd2, 1'b0);
    expectPos(113, 2'd2, 1'b1); expectNeg(114, 2'd2, 1'b0);
    expectPos(115, 2'd2, 1'b1); expectNeg(116, 2'd2, 1'b0);
    expectPos(117, 2'd2, 1'b1); expectNeg(118, 2'd2, 1'b0);
    expectPos(119, 2'd1, 1'b1); expectNeg(121, 2'd1, 1'b0);
    expectPos(123, 2'd1, 1'b1); expectNeg(125, 2'd1, 1'b0);
    expectPos(127, 2'd1, 1'b1);
    applyStimulus(1);
    rfsh_n = 1'b0;
    applyStimulus(2);
    turbo = 2'd3;
    applyStimulus(2);
    wait_req = 1'b1;
    applyStimulus(3);
    checkOutput("switch deferred while stalled", 32'(int_turbo), 2);
    checkOutput("stall covers ph0", 32'(stalled), 1);
    checkOutput("zclk held over ph0", 32'(zclk_out), 1);
    applyStimulus(1);
    wait_req = 1'b0;
    applyStimulus(1);
    checkOutput("stall released", 32'(stalled), 0);
    applyStimulus(5);
    checkOutput("switch waits for ph0", 32'(int_turbo), 2);
    applyStimulus(9);

    $display("[TB] misaligned sync at ph 5");
    expectNeg(129, 2'd1, 1'b0);
    expectPos(131, 2'd1, 1'b1);
    expectPos(133, 2'd1, 1'b0); expectNeg(135, 2'd1, 1'b0);
    expectPos(137, 2'd1, 1'b1); expectNeg(139, 2'd1, 1'b0);
    expectPos(141, 2'd1, 1'b1);
    applyStimulus(4);
    injectSync = 1'b1;
    applyStimulus(1);
    injectSync = 1'b0;
    applyStimulus(9);

    @(negedge fclk);
    #1;
    checkOutput("zpos events outstanding", zposQ.size(), 0);
    checkOutput("zneg events outstanding", znegQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
